// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, state encodings and decode bundle for the multicycle CPU sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD      = 5'd0;
    localparam logic [4:0] OP_SUB      = 5'd1;
    localparam logic [4:0] OP_AND      = 5'd2;
    localparam logic [4:0] OP_OR       = 5'd3;
    localparam logic [4:0] OP_XOR      = 5'd4;
    localparam logic [4:0] OP_NOT      = 5'd5;
    localparam logic [4:0] OP_SHL      = 5'd6;
    localparam logic [4:0] OP_SHR      = 5'd7;
    localparam logic [4:0] OP_CMPEQ    = 5'd14;
    localparam logic [4:0] OP_CMPLT    = 5'd15;
    localparam logic [4:0] OP_CMPLE    = 5'd16;
    localparam logic [4:0] OP_ALU_LAST = OP_CMPLE;
    localparam logic [4:0] OP_BR       = 5'd17;
    localparam logic [4:0] OP_STW      = 5'd18;
    localparam logic [4:0] OP_LDW      = 5'd19;

    // ALU status bit positions, shared with the datapath.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_IR_LD  = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MDR_LD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB     = 4'd8,
        S_PC_UPD = 4'd9,
        S_TRAP   = 4'd10
    } state_e;

    typedef struct packed {
        logic is_alu;
        logic is_br;
        logic is_ld;
        logic is_st;
        logic is_bad;
    } dec_t;

    // States that wait on the memory handshake and are covered by the watchdog.
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier: exactly one of the dec_o bits is set for any opcode.
module cpu_ctrl_decode import cpu_ctrl_pkg::*; #(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] opcode_i,
    output dec_t            dec_o
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        dec_o = '0;
        if (opcode_i <= OP_W'(OP_ALU_LAST))
            dec_o.is_alu = 1'b1;
        else if (opcode_i == OP_W'(OP_BR))
            dec_o.is_br = 1'b1;
        else if (opcode_i == OP_W'(OP_STW))
            dec_o.is_st = 1'b1;
        else if (opcode_i == OP_W'(OP_LDW))
            dec_o.is_ld = 1'b1;
        else
            dec_o.is_bad = 1'b1;
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multicycle Moore sequencer: walks each instruction through fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select from registered state.
module cpu_ctrl import cpu_ctrl_pkg::*; #(
    parameter int OP_W        = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [15:0]      IR,
    input  logic             mem_ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IR_EN,
    output logic             MDR_EN,
    output logic             PC_EN,
    output logic             BR_EN,
    output logic             RFwrite,
    output logic             LDW_EN,
    output logic             dataW_MDR,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_out
);

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    logic             is_load_q, is_load_d;
    logic             is_br_q, is_br_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             step_pend_q, step_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             wd_expire;
    dec_t             dec;
    logic             unused_bits;

    cpu_ctrl_decode #(.OP_W(OP_W)) u_decode (
        .opcode_i (IR[15 -: OP_W]),
        .dec_o    (dec)
    );

    // Operand fields feed the datapath directly; the sequencer only needs the opcode class.
    assign unused_bits = ^{IR[15-OP_W:0], dec.is_alu};

    assign wd_expire = (MEM_TIMEOUT > 0) && is_mem_wait(state_q) && !mem_ready &&
                       (wd_q == WD_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        is_br_d     = is_br_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        step_pend_d = step_pend_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (step && !run)
                    step_pend_d = 1'b1;
                if (run || step || step_pend_q)
                    state_d = S_FETCH;
            end
            S_FETCH:  if (mem_ready) state_d = S_IR_LD;
            S_IR_LD:  state_d = S_DECODE;
            S_DECODE: begin
                is_load_d = dec.is_ld;
                is_br_d   = dec.is_br;
                if (dec.is_bad) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else if (dec.is_br)
                    state_d = S_PC_UPD;
                else if (dec.is_st)
                    state_d = S_MEM_WR;
                else if (dec.is_ld)
                    state_d = S_MEM_RD;
                else
                    state_d = S_EXEC;
            end
            S_EXEC:   state_d = S_WB;
            S_MEM_RD: if (mem_ready) state_d = S_MDR_LD;
            S_MDR_LD: state_d = S_WB;
            S_MEM_WR: if (mem_ready) state_d = S_PC_UPD;
            S_WB:     state_d = S_PC_UPD;
            S_PC_UPD: begin
                cnt_d       = cnt_q + 1'b1;
                step_pend_d = 1'b0;
                state_d     = run ? S_FETCH : S_IDLE;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
        if (wd_expire) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
        end
    end

    // Watchdog restarts on each entry into a wait state, so back-to-back waits never share a budget.
    always_comb begin
        wd_d = wd_q;
        if (is_mem_wait(state_d) && (state_d != state_q))
            wd_d = '0;
        else if (is_mem_wait(state_q) && !mem_ready)
            wd_d = wd_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            is_br_q     <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            step_pend_q <= 1'b0;
            cnt_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            is_br_q     <= is_br_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            step_pend_q <= step_pend_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
        end
    end

    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IR_EN     = 1'b0;
        MDR_EN    = 1'b0;
        PC_EN     = 1'b0;
        BR_EN     = 1'b0;
        RFwrite   = 1'b0;
        LDW_EN    = 1'b0;
        dataW_MDR = 1'b0;
        case (state_q)
            S_FETCH:  MemRead = 1'b1;
            S_IR_LD: begin
                MemRead = 1'b1;
                IR_EN   = 1'b1;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                LDW_EN  = 1'b1;
            end
            S_MDR_LD: begin
                MemRead = 1'b1;
                LDW_EN  = 1'b1;
                MDR_EN  = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                LDW_EN   = 1'b1;
            end
            S_WB: begin
                RFwrite   = 1'b1;
                dataW_MDR = is_load_q;
            end
            S_PC_UPD: begin
                PC_EN = 1'b1;
                BR_EN = is_br_q;
            end
            default: ;
        endcase
    end

    assign halted      = (state_q == S_IDLE) || (state_q == S_TRAP);
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign instr_count = cnt_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction table with a per-instruction scoreboard,
// plus directed sequences for step, illegal trap, watchdog and reset mid-transaction.
module tb_cpu_ctrl;
    import cpu_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        reset, run, step, mem_ready;
    logic [15:0] IR;
    logic        MemRead, MemWrite, IR_EN, MDR_EN, PC_EN, BR_EN, RFwrite, LDW_EN, dataW_MDR;
    logic        halted, illegal, timeout;
    logic [15:0] instr_count;
    logic [3:0]  state_out;

    cpu_ctrl #(.OP_W(5), .CNT_W(16), .MEM_TIMEOUT(8)) dut (
        .CLK(CLK), .reset(reset), .run(run), .step(step), .IR(IR), .mem_ready(mem_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .IR_EN(IR_EN), .MDR_EN(MDR_EN), .PC_EN(PC_EN),
        .BR_EN(BR_EN), .RFwrite(RFwrite), .LDW_EN(LDW_EN), .dataW_MDR(dataW_MDR),
        .halted(halted), .illegal(illegal), .timeout(timeout),
        .instr_count(instr_count), .state_out(state_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] op;
        int         rd_wait;
        logic       trap;
        int         cyc;
        int         rf;
        logic       dw;
        logic       br;
        int         mw;
        int         mdr;
        int         rd;
        int         ldw;
    } vec_t;

    vec_t stim_q[$];
    vec_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [4:0] op, input int w, input logic trap, input int cyc,
                                input int rf, input logic dw, input logic br, input int mw,
                                input int mdr, input int rd, input int ldw);
        vec_t v;
        v.op = op; v.rd_wait = w; v.trap = trap; v.cyc = cyc; v.rf = rf; v.dw = dw;
        v.br = br; v.mw = mw; v.mdr = mdr; v.rd = rd; v.ldw = ldw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (state_out !== s && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(state_out), 32'(s));
    endtask

    // Monitor, scoreboard and memory responder share one negedge process for deterministic order.
    logic [3:0] prev_state = 4'd0;
    int         wcnt = 0, cur_wait = 0;
    logic       fetch_hang = 1'b0, wr_hang = 1'b0;
    logic       m_active = 1'b0;
    int         m_cyc = 0, m_rf = 0, m_mw = 0, m_mdr = 0, m_rd = 0, m_ldw = 0, m_pcen = 0;
    logic       m_dw = 1'b0;
    int         both_seen = 0, halted_bad = 0;

    always @(negedge CLK) begin
        vec_t v, e;
        if (MemRead && MemWrite) both_seen++;
        if (halted !== (state_out == 4'd0 || state_out == 4'd10)) halted_bad++;
        if (reset) begin
            m_active = 1'b0;
            wcnt     = 0;
        end else begin
            if (state_out == 4'd1 && prev_state != 4'd1) begin
                if (stim_q.size() == 0)
                    check("unexpected_fetch", 1, 0);
                else begin
                    v = stim_q.pop_front();
                    IR = {v.op, 1'b0, 5'b00101, 5'b00000};
                    cur_wait = v.rd_wait;
                    if (!v.trap) sb_q.push_back(v);
                end
                m_active = 1'b1;
                m_cyc = 0; m_rf = 0; m_mw = 0; m_mdr = 0; m_rd = 0; m_ldw = 0; m_pcen = 0;
                m_dw = 1'b0;
            end
            if (state_out != prev_state) wcnt = 0;
            if (m_active) begin
                m_cyc++;
                if (RFwrite) begin m_rf++; m_dw = dataW_MDR; end
                if (MemWrite) m_mw++;
                if (MDR_EN) m_mdr++;
                if (MemRead) m_rd++;
                if (LDW_EN) m_ldw++;
                if (PC_EN) m_pcen++;
            end
            if (state_out == 4'd9 && m_active) begin
                m_active = 1'b0;
                if (sb_q.size() == 0)
                    check("sb_underflow", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    check($sformatf("op%0d_cycles", e.op), m_cyc, e.cyc);
                    check($sformatf("op%0d_rfwrite", e.op), m_rf, e.rf);
                    check($sformatf("op%0d_dataw_mdr", e.op), 32'(m_dw), 32'(e.dw));
                    check($sformatf("op%0d_br_en", e.op), 32'(BR_EN & PC_EN), 32'(e.br));
                    check($sformatf("op%0d_memwrite", e.op), m_mw, e.mw);
                    check($sformatf("op%0d_mdr_en", e.op), m_mdr, e.mdr);
                    check($sformatf("op%0d_memread", e.op), m_rd, e.rd);
                    check($sformatf("op%0d_ldw_en", e.op), m_ldw, e.ldw);
                end
            end
            case (state_out)
                4'd1: mem_ready = !fetch_hang;
                4'd5: begin
                    mem_ready = (wcnt >= cur_wait);
                    wcnt++;
                end
                4'd7: mem_ready = !wr_hang;
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
        prev_state = state_out;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vec_t tbl[8];
        int   n;
        reset = 1'b1; run = 1'b0; step = 1'b0; IR = 16'h0; mem_ready = 1'b0;

        //           op        wait trap cyc rf dw br mw mdr rd ldw
        tbl[0] = mk(OP_ADD,    0,   0,   6,  1, 0, 0, 0, 0,  2, 0);
        tbl[1] = mk(OP_SUB,    0,   0,   6,  1, 0, 0, 0, 0,  2, 0);
        tbl[2] = mk(OP_BR,     0,   0,   4,  0, 0, 1, 0, 0,  2, 0);
        tbl[3] = mk(OP_STW,    0,   0,   5,  0, 0, 0, 1, 0,  2, 1);
        tbl[4] = mk(OP_LDW,    0,   0,   7,  1, 1, 0, 0, 1,  4, 2);
        tbl[5] = mk(OP_CMPLE,  0,   0,   6,  1, 0, 0, 0, 0,  2, 0);
        tbl[6] = mk(OP_LDW,    3,   0,   10, 1, 1, 0, 0, 1,  7, 5);
        tbl[7] = mk(OP_NOT,    0,   0,   6,  1, 0, 0, 0, 0,  2, 0);

        repeat (2) @(negedge CLK);
        check("rst_state", 32'(state_out), 0);
        check("rst_halted", 32'(halted), 1);
        check("rst_memread", 32'(MemRead), 0);
        check("rst_pc_en", 32'(PC_EN), 0);
        check("rst_rfwrite", 32'(RFwrite), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_count", 32'(instr_count), 0);
        reset = 1'b0;

        // Free-running program; run drops while the last instruction is in flight.
        foreach (tbl[i]) stim_q.push_back(tbl[i]);
        @(negedge CLK);
        run = 1'b1;
        n = 0;
        while (stim_q.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("prog_drain", stim_q.size(), 0);
        run = 1'b0;
        wait_state(4'd0, 50, "prog_idle");
        check("prog_count", 32'(instr_count), 8);
        check("prog_sb_empty", sb_q.size(), 0);

        // Single step, with a second step pulse while busy that must be ignored.
        stim_q.push_back(mk(OP_AND, 0, 0, 6, 1, 0, 0, 0, 0, 2, 0));
        @(negedge CLK); step = 1'b1;
        @(negedge CLK); step = 1'b0;
        repeat (3) @(negedge CLK);
        step = 1'b1;
        @(negedge CLK); step = 1'b0;
        wait_state(4'd0, 50, "step_idle");
        check("step_count", 32'(instr_count), 9);
        check("step_halted", 32'(halted), 1);
        repeat (10) @(negedge CLK);
        check("step_stays_idle", 32'(state_out), 0);
        check("step_count_hold", 32'(instr_count), 9);

        // Illegal opcode traps and is sticky until reset.
        stim_q.push_back(mk(5'b10110, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run = 1'b1;
        wait_state(4'd10, 30, "illegal_trap");
        check("illegal_flag", 32'(illegal), 1);
        check("illegal_halted", 32'(halted), 1);
        check("illegal_no_rfwrite", m_rf, 0);
        check("illegal_no_pc_en", m_pcen, 0);
        check("illegal_count", 32'(instr_count), 9);
        repeat (5) @(negedge CLK);
        check("trap_holds", 32'(state_out), 10);
        check("trap_memread", 32'(MemRead), 0);
        run = 1'b0; reset = 1'b1;
        @(negedge CLK);
        check("illegal_rst_state", 32'(state_out), 0);
        check("illegal_rst_flag", 32'(illegal), 0);
        check("illegal_rst_count", 32'(instr_count), 0);
        reset = 1'b0;

        // Watchdog: memory never answers in FETCH.
        fetch_hang = 1'b1;
        stim_q.push_back(mk(OP_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run = 1'b1;
        wait_state(4'd1, 10, "wd_fetch");
        n = 0;
        while (state_out == 4'd1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("wd_latency", n, 8);
        check("wd_state", 32'(state_out), 10);
        check("wd_timeout", 32'(timeout), 1);
        check("wd_illegal", 32'(illegal), 0);
        check("wd_memread_drop", 32'(MemRead), 0);
        run = 1'b0; fetch_hang = 1'b0; reset = 1'b1;
        @(negedge CLK);
        check("wd_rst_timeout", 32'(timeout), 0);
        reset = 1'b0;

        // Reset while a store is stalled in MEM_WR.
        wr_hang = 1'b1;
        stim_q.push_back(mk(OP_STW, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run = 1'b1;
        wait_state(4'd7, 20, "mw_enter");
        check("mw_memwrite", 32'(MemWrite), 1);
        @(negedge CLK);
        check("mw_no_pc_en", m_pcen, 0);
        reset = 1'b1;
        @(negedge CLK);
        check("mw_rst_memwrite", 32'(MemWrite), 0);
        check("mw_rst_state", 32'(state_out), 0);
        check("mw_rst_rfwrite", 32'(RFwrite), 0);
        run = 1'b0; wr_hang = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        repeat (3) @(negedge CLK);

        check("end_sb_empty", sb_q.size(), 0);
        check("end_stim_empty", stim_q.size(), 0);
        check("rd_wr_exclusive", both_seen, 0);
        check("halted_consistent", halted_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
